node_mem_arb: RTL and testbench

- Shares the single port B of the octree node BRAM (152-bit node words: 8 x 16-bit child pointers in [151:24], 24-bit payload in [23:0]) between two requesters.
- Master 0 is the octant builder (read/write, may lock for read-modify-write). Master 1 is the BFS traversal core (read only).
- Round-robin arbitration, one BRAM access per cycle.
- Returns read data to the issuing master with a valid strobe, aligned to the BRAM read latency.

---
 rtl/node_mem_arb.sv | 164 ++++++++++++++++
 tb/tb_node_mem_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/node_mem_arb.sv
// Two-master round-robin arbiter for port B of the octree node BRAM, with master-0 lock and tagged read return.
// Optional grant/stall statistics counters are built when NODE_ARB_STATS_EN is defined.
module node_mem_arb #(
   parameter int unsigned DATA_W = 152,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_m0_req,
   input  logic              i_m0_we,
   input  logic              i_m0_lock,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [DATA_W-1:0] i_m0_wdata,
   output logic              o_m0_gnt,
   output logic              o_m0_rvalid,
   output logic [DATA_W-1:0] o_m0_rdata,
   input  logic              i_m1_req,
   input  logic [ADDR_W-1:0] i_m1_addr,
   output logic              o_m1_gnt,
   output logic              o_m1_rvalid,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic              o_enb,
   output logic              o_web,
   output logic [ADDR_W-1:0] o_addrb,
   output logic [DATA_W-1:0] o_dinb,
   input  logic [DATA_W-1:0] i_doutb
`ifdef NODE_ARB_STATS_EN
  ,output logic [31:0]       o_m0_grants,
   output logic [31:0]       o_m1_grants,
   output logic [31:0]       o_m1_stall
`endif
);

   typedef enum logic {S_IDLE = 1'b0, S_LOCK0 = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              rr_m1_q, rr_m1_d;   // 1: M1 wins the next contention
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [RD_LAT-1:0] tag_q, tag_d;       // 1: read belongs to M1
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              gnt0_c, gnt1_c, rd_new_c, rvalid0_c, rvalid1_c;

   // Arbitration, lock FSM and BRAM port mux
   always_comb begin
      gnt0_c  = 1'b0;
      gnt1_c  = 1'b0;
      state_d = state_q;
      rr_m1_d = rr_m1_q;
      addr_d  = addr_q;
      din_d   = din_q;
      if (i_rst_n) begin
         case (state_q)
            S_IDLE: begin
               if (i_m0_req && i_m1_req) begin
                  gnt1_c = rr_m1_q;
                  gnt0_c = ~rr_m1_q;
               end else begin
                  gnt0_c = i_m0_req;
                  gnt1_c = i_m1_req;
               end
               if (gnt0_c) begin
                  rr_m1_d = 1'b1;
                  if (i_m0_lock) state_d = S_LOCK0;
               end
               if (gnt1_c) rr_m1_d = 1'b0;
            end
            S_LOCK0: begin
               gnt0_c  = i_m0_req;
               rr_m1_d = 1'b1;
               if (gnt0_c && !i_m0_lock) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (gnt0_c) begin
         addr_d = i_m0_addr;
         din_d  = i_m0_wdata;
      end else if (gnt1_c) begin
         addr_d = i_m1_addr;
      end
   end

   assign o_m0_gnt = gnt0_c;
   assign o_m1_gnt = gnt1_c;
   assign o_enb    = gnt0_c | gnt1_c;
   assign o_web    = gnt0_c & i_m0_we;
   assign o_addrb  = addr_d;
   assign o_dinb   = din_d;

   // Valid/tag pipeline matched to the BRAM read latency
   always_comb begin
      rd_new_c  = (gnt0_c & ~i_m0_we) | gnt1_c;
      vld_d     = RD_LAT'({vld_q, rd_new_c});
      tag_d     = RD_LAT'({tag_q, gnt1_c});
      rvalid0_c = vld_q[RD_LAT-1] & ~tag_q[RD_LAT-1];
      rvalid1_c = vld_q[RD_LAT-1] &  tag_q[RD_LAT-1];
      rdata0_d  = rvalid0_c ? i_doutb : rdata0_q;
      rdata1_d  = rvalid1_c ? i_doutb : rdata1_q;
   end

   assign o_m0_rvalid = rvalid0_c;
   assign o_m1_rvalid = rvalid1_c;
   assign o_m0_rdata  = rdata0_d;
   assign o_m1_rdata  = rdata1_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         rr_m1_q  <= 1'b1;
         addr_q   <= '0;
         din_q    <= '0;
         vld_q    <= '0;
         tag_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_m1_q  <= rr_m1_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         vld_q    <= vld_d;
         tag_q    <= tag_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

`ifdef NODE_ARB_STATS_EN
   logic [31:0] m0_grants_q, m0_grants_d;
   logic [31:0] m1_grants_q, m1_grants_d;
   logic [31:0] m1_stall_q, m1_stall_d;

   // Saturating statistics counters
   always_comb begin
      m0_grants_d = m0_grants_q;
      m1_grants_d = m1_grants_q;
      m1_stall_d  = m1_stall_q;
      if (gnt0_c && (m0_grants_q != '1)) m0_grants_d = m0_grants_q + 32'd1;
      if (gnt1_c && (m1_grants_q != '1)) m1_grants_d = m1_grants_q + 32'd1;
      if (i_m1_req && !gnt1_c && (m1_stall_q != '1)) m1_stall_d = m1_stall_q + 32'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m0_grants_q <= '0;
         m1_grants_q <= '0;
         m1_stall_q  <= '0;
      end else begin
         m0_grants_q <= m0_grants_d;
         m1_grants_q <= m1_grants_d;
         m1_stall_q  <= m1_stall_d;
      end
   end

   assign o_m0_grants = m0_grants_q;
   assign o_m1_grants = m1_grants_q;
   assign o_m1_stall  = m1_stall_q;
`endif

endmodule

// File: tb/tb_node_mem_arb.sv
// Directed bench for node_mem_arb with a read-after-write BRAM model of latency 2.
module tb_node_mem_arb;
   localparam int unsigned DATA_W = 152;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned RD_LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata, m0_rdata;
   logic              m1_req, m1_gnt, m1_rvalid;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_rdata;
   logic              enb, web;
   logic [ADDR_W-1:0] addrb;
   logic [DATA_W-1:0] dinb, doutb;
`ifdef NODE_ARB_STATS_EN
   logic [31:0]       m0_grants, m1_grants, m1_stall;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [DATA_W-1:0] w0, w1, w2, w3, ww3, w7, wz;
   logic [DATA_W-1:0] mem [0:7];
   logic [DATA_W-1:0] rd_p0, rd_p1;
   logic              load = 1'b1;
   logic              exp_g0, exp_g1, exp_v0, exp_v1;
   logic [15:0]       hi16;

   node_mem_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_m0_req    (m0_req),
      .i_m0_we     (m0_we),
      .i_m0_lock   (m0_lock),
      .i_m0_addr   (m0_addr),
      .i_m0_wdata  (m0_wdata),
      .o_m0_gnt    (m0_gnt),
      .o_m0_rvalid (m0_rvalid),
      .o_m0_rdata  (m0_rdata),
      .i_m1_req    (m1_req),
      .i_m1_addr   (m1_addr),
      .o_m1_gnt    (m1_gnt),
      .o_m1_rvalid (m1_rvalid),
      .o_m1_rdata  (m1_rdata),
      .o_enb       (enb),
      .o_web       (web),
      .o_addrb     (addrb),
      .o_dinb      (dinb),
      .i_doutb     (doutb)
`ifdef NODE_ARB_STATS_EN
     ,.o_m0_grants (m0_grants),
      .o_m1_grants (m1_grants),
      .o_m1_stall  (m1_stall)
`endif
   );

   // BRAM port B model: read-after-write, two-cycle read latency
   always @(posedge clk) begin
      if (load) begin
         mem[0] <= w0;  mem[1] <= w1; mem[2] <= w2; mem[3] <= w3;
         mem[4] <= wz;  mem[5] <= wz; mem[6] <= wz; mem[7] <= wz;
      end else if (enb && web) begin
         mem[addrb[2:0]] <= dinb;
      end
      rd_p0 <= mem[addrb[2:0]];
      rd_p1 <= rd_p0;
   end
   assign doutb = rd_p1;

   task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, act, exp);
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_gnt0"},  DATA_W'(m0_gnt), '0);
      check({tag, "_gnt1"},  DATA_W'(m1_gnt), '0);
      check({tag, "_enb"},   DATA_W'(enb), '0);
      check({tag, "_web"},   DATA_W'(web), '0);
      check({tag, "_addrb"}, DATA_W'(addrb), '0);
      check({tag, "_dinb"},  dinb, '0);
      check({tag, "_rv0"},   DATA_W'(m0_rvalid), '0);
      check({tag, "_rv1"},   DATA_W'(m1_rvalid), '0);
      check({tag, "_rd0"},   m0_rdata, '0);
      check({tag, "_rd1"},   m1_rdata, '0);
   endtask

   initial begin
      wz  = '0;
      w0  = '0; w0[39:24]   = 16'd7;      w0[103:88] = 16'd3;
      w1  = '0; w1[151:136] = 16'h1111;   w1[23:0]   = 24'h0000A1;
      w2  = '0; w2[151:136] = 16'h2222;   w2[23:0]   = 24'h0000B2;
      w3  = '0; w3[55:40]   = 16'h0033;   w3[23:0]   = 24'h0000C3;
      ww3 = '0; ww3[71:56]  = 16'h0044;   ww3[23:0]  = 24'h0000D4;
      w7  = '0; w7[151:136] = 16'd8;      w7[23:0]   = 24'h0000E7;
      rst_n = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_addr = '0;

      settle();
      check_quiet("rst");
      next();
      load = 1'b0;
      next();
      rst_n = 1'b1;

      // Continuous contention: M1 first, then strict alternation
      for (int i = 0; i < 12; i++) begin
         m0_req = (i < 10); m0_addr = 16'h0001;
         m1_req = (i < 10); m1_addr = 16'h0002;
         settle();
         exp_g1 = (i < 10) && (i % 2 == 0);
         exp_g0 = (i < 10) && (i % 2 == 1);
         check("rr_gnt1", DATA_W'(m1_gnt), DATA_W'(exp_g1));
         check("rr_gnt0", DATA_W'(m0_gnt), DATA_W'(exp_g0));
         if (i >= 2) begin
            exp_v1 = ((i - 2) % 2 == 0) && (i - 2 < 10);
            exp_v0 = ((i - 2) % 2 == 1) && (i - 2 < 10);
            check("rr_rv1", DATA_W'(m1_rvalid), DATA_W'(exp_v1));
            check("rr_rv0", DATA_W'(m0_rvalid), DATA_W'(exp_v0));
            if (exp_v1) check("rr_rd1", m1_rdata, w2);
            if (exp_v0) check("rr_rd0", m0_rdata, w1);
         end
         next();
      end
`ifdef NODE_ARB_STATS_EN
      check("st_m0g", DATA_W'(m0_grants), DATA_W'(32'd5));
      check("st_m1g", DATA_W'(m1_grants), DATA_W'(32'd5));
      check("st_m1s", DATA_W'(m1_stall),  DATA_W'(32'd5));
`endif

      // M1 alone reads address 0
      m1_req = 1'b1; m1_addr = 16'h0000;
      settle();
      check("solo_gnt1", DATA_W'(m1_gnt), DATA_W'(1'b1));
      check("solo_gnt0", DATA_W'(m0_gnt), '0);
      check("solo_enb",  DATA_W'(enb), DATA_W'(1'b1));
      check("solo_web",  DATA_W'(web), '0);
      check("solo_addr", DATA_W'(addrb), '0);
      next();
      m1_req = 1'b0;
      settle();
      check("solo_rv1_early", DATA_W'(m1_rvalid), '0);
      next();
      settle();
      check("solo_rv1", DATA_W'(m1_rvalid), DATA_W'(1'b1));
      check("solo_rd1", m1_rdata, w0);
      check("solo_rv0", DATA_W'(m0_rvalid), '0);
      next();
      settle();
      check("solo_rv1_off", DATA_W'(m1_rvalid), '0);
      check("solo_rd1_hold", m1_rdata, w0);
      next();

      // M0 locked read-modify-write of address 3 while M1 waits
      m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b1; m0_addr = 16'h0003;
      m1_req = 1'b1; m1_addr = 16'h0003;
      settle();
      check("lk_a_gnt0", DATA_W'(m0_gnt), DATA_W'(1'b1));
      check("lk_a_gnt1", DATA_W'(m1_gnt), '0);
      next();
      m0_req = 1'b0;
      settle();
      check("lk_hold_gnt1", DATA_W'(m1_gnt), '0);
      check("lk_hold_enb",  DATA_W'(enb), '0);
      next();
      m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b0; m0_wdata = ww3;
      settle();
      check("lk_b_gnt0", DATA_W'(m0_gnt), DATA_W'(1'b1));
      check("lk_b_gnt1", DATA_W'(m1_gnt), '0);
      check("lk_b_web",  DATA_W'(web), DATA_W'(1'b1));
      check("lk_b_dinb", dinb, ww3);
      check("lk_b_rv0",  DATA_W'(m0_rvalid), DATA_W'(1'b1));
      check("lk_b_rd0",  m0_rdata, w3);
      next();
      m0_req = 1'b0; m0_we = 1'b0;
      settle();
      check("lk_c_gnt1", DATA_W'(m1_gnt), DATA_W'(1'b1));
      check("lk_c_rv0",  DATA_W'(m0_rvalid), '0);
      next();
      m1_req = 1'b0;
      settle();
      check("lk_wr_rv1", DATA_W'(m1_rvalid), '0);
      next();
      settle();
      check("lk_rv1", DATA_W'(m1_rvalid), DATA_W'(1'b1));
      check("lk_rd1", m1_rdata, ww3);
      next();

      // Write then read of address 7 from different masters back to back
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0007; m0_wdata = w7;
      m1_req = 1'b1; m1_addr = 16'h0007;
      settle();
      check("raw_gnt0", DATA_W'(m0_gnt), DATA_W'(1'b1));
      check("raw_gnt1", DATA_W'(m1_gnt), '0);
      check("raw_web",  DATA_W'(web), DATA_W'(1'b1));
      check("raw_addr", DATA_W'(addrb), DATA_W'(16'h0007));
      check("raw_dinb", dinb, w7);
      next();
      m0_req = 1'b0; m0_we = 1'b0;
      settle();
      check("raw_gnt1b", DATA_W'(m1_gnt), DATA_W'(1'b1));
      check("raw_webb",  DATA_W'(web), '0);
      next();
      m1_req = 1'b0;
      settle();
      check("raw_wr_rv0", DATA_W'(m0_rvalid), '0);
      check("raw_wr_rv1", DATA_W'(m1_rvalid), '0);
      check("raw_idle_enb", DATA_W'(enb), '0);
      check("raw_idle_addr", DATA_W'(addrb), DATA_W'(16'h0007));
      next();
      settle();
      check("raw_rv1", DATA_W'(m1_rvalid), DATA_W'(1'b1));
      hi16 = m1_rdata[151:136];
      check("raw_hi16", DATA_W'(hi16), DATA_W'(16'd8));
      check("raw_rd1", m1_rdata, w7);
      next();

      // Reset one cycle after an M1 read grant discards the read
      m1_req = 1'b1; m1_addr = 16'h0000;
      settle();
      check("mr_gnt1", DATA_W'(m1_gnt), DATA_W'(1'b1));
      next();
      rst_n = 1'b0; m0_req = 1'b1;
      settle();
      check_quiet("mr_rst1");
      next();
      settle();
      check_quiet("mr_rst2");
      next();
      rst_n = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         settle();
         check("mr_post_rv1", DATA_W'(m1_rvalid), '0);
         check("mr_post_rv0", DATA_W'(m0_rvalid), '0);
         next();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
